// File: rtl/cell_cfg_loader_if.sv
// rtl/cell_cfg_loader_if.sv - serial configuration bit stream handshake bundle
interface cell_cfg_loader_if;
   logic cfg_start;
   logic cfg_valid;
   logic cfg_bit;
   logic cfg_ready;

   modport master (
      output cfg_start,
      output cfg_valid,
      output cfg_bit,
      input  cfg_ready
   );

   modport slave (
      input  cfg_start,
      input  cfg_valid,
      input  cfg_bit,
      output cfg_ready
   );
endinterface

// File: rtl/cell_cfg_loader.sv
// rtl/cell_cfg_loader.sv - framed even-parity serial loader with atomic commit to cell config bus
// Optional readback of the committed config is enabled by defining CFG_READBACK_EN.
module cell_cfg_loader #(
   parameter int NUM_CELLS = 4,
   parameter int CFG_W     = NUM_CELLS * 4
) (
   input  logic                 clk,
   input  logic                 clr,
   cell_cfg_loader_if.slave     cfg,
   output logic                 busy,
   output logic [CFG_W-1:0]     cfg_data,
   output logic                 cfg_done,
   output logic                 cfg_err
`ifdef CFG_READBACK_EN
   ,
   input  logic                 rb_req,
   output logic                 rb_valid,
   output logic                 rb_bit
`endif
);

   localparam int CNT_W = $clog2(CFG_W + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_PARITY = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_RB     = 3'd4;

   logic [2:0]       state;
   logic [CFG_W-1:0] shadow;
   logic [CNT_W-1:0] cnt;
   logic             par_ok;
   logic             commit_stb;

   assign cfg.cfg_ready = (state == S_LOAD) || (state == S_PARITY);
   assign busy          = (state != S_IDLE);

`ifdef CFG_READBACK_EN
   logic rb_par;

   // During readback the shadow register doubles as the outgoing shift register.
   assign rb_valid = (state == S_RB);
   assign rb_bit   = rb_valid & ((cnt == CNT_W'(CFG_W)) ? rb_par : shadow[CFG_W-1]);
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= S_IDLE;
         shadow     <= '0;
         cnt        <= '0;
         par_ok     <= 1'b0;
         commit_stb <= 1'b0;
         cfg_data   <= '0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
`ifdef CFG_READBACK_EN
         rb_par     <= 1'b0;
`endif
      end else begin
         commit_stb <= 1'b0;
         cfg_done   <= commit_stb & par_ok;

         // Commit lands one edge after COMMIT; a start on that same edge still clears cfg_err below.
         if (commit_stb) begin
            if (par_ok) cfg_data <= shadow;
            else        cfg_err  <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (cfg.cfg_start) begin
                  state   <= S_LOAD;
                  shadow  <= '0;
                  cnt     <= '0;
                  cfg_err <= 1'b0;
               end
`ifdef CFG_READBACK_EN
               else if (rb_req && !commit_stb) begin
                  state  <= S_RB;
                  shadow <= cfg_data;
                  rb_par <= ^cfg_data;
                  cnt    <= '0;
               end
`endif
            end
            S_LOAD: begin
               if (cfg.cfg_start) begin
                  shadow  <= '0;
                  cnt     <= '0;
                  cfg_err <= 1'b0;
               end else if (cfg.cfg_valid) begin
                  shadow <= {shadow[CFG_W-2:0], cfg.cfg_bit};
                  cnt    <= cnt + 1'b1;
                  if (cnt == CNT_W'(CFG_W - 1)) state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (cfg.cfg_start) begin
                  state   <= S_LOAD;
                  shadow  <= '0;
                  cnt     <= '0;
                  cfg_err <= 1'b0;
               end else if (cfg.cfg_valid) begin
                  par_ok <= (cfg.cfg_bit == ^shadow);
                  state  <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               state      <= S_IDLE;
               commit_stb <= 1'b1;
            end
`ifdef CFG_READBACK_EN
            S_RB: begin
               shadow <= {shadow[CFG_W-2:0], 1'b0};
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(CFG_W)) state <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
